// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: op/state encodings and ALU control codes shared by the CPU datapath
package mul_div_unit_pkg;
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } md_state_e;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_ctrl_e;
    function automatic logic op_is_signed(md_op_e o);
        return o == OP_MULT || o == OP_DIV;
    endfunction
    function automatic logic op_is_div(md_op_e o);
        return o == OP_DIV || o == OP_DIVU;
    endfunction
endpackage

// File: rtl/mul_div_unit_step.sv
// mul_div_step: one shift-add (multiply) or restoring shift-subtract (divide) iteration
module mul_div_step
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] shreg,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] shreg_next
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           ge;
    always_comb begin
        sum        = {1'b0, acc} + (shreg[0] ? {1'b0, b} : '0);
        shifted    = {acc, shreg[WIDTH-1]};
        ge         = shifted >= {1'b0, b};
        acc_next   = is_div ? (ge ? WIDTH'(shifted - {1'b0, b}) : shifted[WIDTH-1:0]) : sum[WIDTH:1];
        shreg_next = is_div ? {shreg[WIDTH-2:0], ge} : {sum[0], shreg[WIDTH-1:1]};
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: 33-cycle iterative MULT/MULTU/DIV/DIVU with HI/LO registers and mthi/mtlo
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    md_state_e          state;
    md_op_e             op_q;
    md_op_e             op_in;
    logic [5:0]         cnt;
    logic               sign_a, sign_b, sa_in, sb_in;
    logic [WIDTH-1:0]   acc, shreg, divisor, a_orig;
    logic [WIDTH-1:0]   acc_next, shreg_next;
    logic [WIDTH-1:0]   a_abs, b_abs, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;
    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .is_div     (op_is_div(op_q)),
        .acc        (acc),
        .shreg      (shreg),
        .b          (divisor),
        .acc_next   (acc_next),
        .shreg_next (shreg_next)
    );
    // Sign flags are only ever set for signed ops, so they alone drive the fix-up.
    always_comb begin
        op_in  = md_op_e'(op);
        sa_in  = op_is_signed(op_in) & A[WIDTH-1];
        sb_in  = op_is_signed(op_in) & B[WIDTH-1];
        a_abs  = sa_in ? -A : A;
        b_abs  = sb_in ? -B : B;
        prod   = (op_q == OP_MULT && (sign_a ^ sign_b)) ? -{acc, shreg} : {acc, shreg};
        res_hi = !op_is_div(op_q) ? prod[2*WIDTH-1:WIDTH] : (divisor == '0) ? a_orig : sign_a ? -acc : acc;
        res_lo = !op_is_div(op_q) ? prod[WIDTH-1:0] : (divisor == '0) ? '1 : (sign_a ^ sign_b) ? -shreg : shreg;
        busy   = state != S_IDLE;
    end
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            divByZero <= 1'b0;
        end else begin
            done      <= 1'b0;
            divByZero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op_in;
                        sign_a  <= sa_in;
                        sign_b  <= sb_in;
                        acc     <= '0;
                        shreg   <= a_abs;
                        divisor <= b_abs;
                        a_orig  <= A;
                        cnt     <= '0;
                        state   <= S_RUN;
                    end else begin
                        if (hiWrite) hi <= writeData;
                        if (loWrite) lo <= writeData;
                    end
                end
                S_RUN: begin
                    acc   <= acc_next;
                    shreg <= shreg_next;
                    cnt   <= cnt + 6'd1;
                    if (cnt == 6'(WIDTH - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    hi        <= res_hi;
                    lo        <= res_lo;
                    done      <= 1'b1;
                    divByZero <= op_is_div(op_q) && divisor == '0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against an arithmetic model
module tb_mul_div_unit;
    logic        clock = 1'b0;
    logic        resetN, start, hiWrite, loWrite;
    logic [1:0]  op;
    logic [31:0] A, B, writeData;
    logic        busy, done, divByZero;
    logic [31:0] hi, lo;
    logic [31:0] model_hi, model_lo;
    int          checks = 0;
    int          errors = 0;
    mul_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .resetN(resetN), .start(start), .op(op), .A(A), .B(B),
        .hiWrite(hiWrite), .loWrite(loWrite), .writeData(writeData),
        .busy(busy), .done(done), .divByZero(divByZero), .hi(hi), .lo(lo)
    );
    always #5 clock = ~clock;
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    // {hi, lo} straight from the arithmetic meaning of each op
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin p = sa * sb; return p; end
            2'b01: begin up = {32'b0, a} * {32'b0, b}; return up; end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction
    task automatic mt(input bit hw, input bit lw, input logic [31:0] d);
        hiWrite = hw; loWrite = lw; writeData = d;
        tick();
        hiWrite = 0; loWrite = 0;
        if (hw) model_hi = d;
        if (lw) model_lo = d;
        check("mt_hi", hi, model_hi);
        check("mt_lo", lo, model_lo);
    endtask
    // Returns in the done cycle, so a following call starts back-to-back.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit with_mt, input bit disturb);
        logic [63:0] exp;
        int k, busy_n;
        exp = model(o, a, b);
        start = 1; op = o; A = a; B = b;
        if (with_mt) begin hiWrite = 1; loWrite = 1; writeData = $urandom; end
        tick();
        start = 0; hiWrite = 0; loWrite = 0;
        check("busy_acc", busy, 1);
        check("hi_acc", hi, model_hi);
        check("lo_acc", lo, model_lo);
        busy_n = busy;
        k = 1;
        while (k < 100) begin
            if (disturb && k == 5) begin
                start = 1; op = 2'($urandom); A = $urandom; B = $urandom;
                hiWrite = 1; loWrite = 1; writeData = 32'h1234;
            end
            tick();
            start = 0; hiWrite = 0; loWrite = 0;
            if (disturb && k == 5) begin
                check("hi_hold", hi, model_hi);
                check("lo_hold", lo, model_lo);
            end
            k++;
            if (done) break;
            busy_n += busy;
        end
        check("latency", k - 1, 33);
        check("busy_cycles", busy_n, 33);
        check("busy_done", busy, 0);
        check("hi", hi, exp[63:32]);
        check("lo", lo, exp[31:0]);
        check("div_by_zero", divByZero, o[1] && b == 0);
        model_hi = exp[63:32];
        model_lo = exp[31:0];
    endtask
    initial begin
        bit seen;
        resetN = 0; start = 0; op = 0; A = 0; B = 0;
        hiWrite = 0; loWrite = 0; writeData = 0;
        model_hi = 0; model_lo = 0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", divByZero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        resetN = 1;
        tick();
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        tick();
        do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
        do_op(2'b11, 32'd100, 32'd7, 0, 0);
        check("divu_b2b", {hi, lo}, {32'd2, 32'd14});
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op(2'b11, 32'd5, 32'd0, 0, 0);
        check("dbz_pulse", divByZero & done, 1);
        tick();
        check("done_once", done, 0);
        check("dbz_once", divByZero, 0);
        do_op(2'b01, 32'd6, 32'd7, 0, 1);
        tick();
        mt(0, 1, 32'hABCD);
        // reset during RUN discards the multiply
        start = 1; op = 2'b01; A = 3; B = 4;
        tick();
        start = 0;
        repeat (9) tick();
        resetN = 0;
        tick();
        resetN = 1;
        model_hi = 0; model_lo = 0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_hi", hi, 0);
        check("mid_rst_lo", lo, 0);
        check("mid_rst_done", done, 0);
        seen = 0;
        repeat (40) begin
            tick();
            if (done) seen = 1;
        end
        check("mid_rst_no_done", seen, 0);
        do_op(2'b01, 32'd3, 32'd4, 0, 0);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) mt($urandom_range(0, 1), $urandom_range(0, 1), $urandom);
            if ($urandom_range(0, 2) == 0) tick();
            do_op(2'($urandom), pick(), pick(), $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have port clock  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port resetN  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  in  1  request; operands and op sampled when accepted.
REQ-005 SHALL have port op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports A and B  in  32 each  A is multiplicand/dividend; B is multiplier/divisor.
REQ-007 SHALL have ports hiWrite and loWrite  in  1 each  mthi/mtlo strobes.
REQ-008 SHALL have port writeData  in  32  mthi/mtlo data.
REQ-009 SHALL have port busy  out  1  high while an operation is in progress.
REQ-010 SHALL have port done  out  1  one-cycle pulse when hi/lo take a new result.
REQ-011 SHALL have port divByZero  out  1  pulses together with done when a DIV/DIVU had B==0.
REQ-012 SHALL have ports hi and lo  out  32 each  registered HI/LO, read by mfhi/mflo.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> FIX -> IDLE; busy = (state != IDLE).
REQ-014 SHALL accept start only in IDLE; on acceptance (edge E0):
  - latch op;
  - latch |A| and |B| for signed ops, raw values for unsigned;
  - latch the result signs;
  - clear the iteration counter;
  - go to RUN.
REQ-015 SHALL ignore start while busy; no queuing.
REQ-016 SHALL in RUN perform one iteration per edge (E0+1..E0+32), using a 6-bit counter:
  - multiply: shift-add, 64-bit product;
  - divide: restoring shift-subtract, 33-bit partial remainder.
REQ-017 SHALL go to FIX after the 32nd iteration.
REQ-018 SHALL at edge E0+33, in FIX:
  - apply sign correction;
  - write hi/lo;
  - assert done (and divByZero if applicable) for exactly the following cycle;
  - return to IDLE.
  Total latency is 33 cycles from accepting edge to result.
REQ-019 SHALL for MULT/MULTU set hi = product[63:32] and lo = product[31:0]; MULT negates the 64-bit product when sign(A) != sign(B).
REQ-020 SHALL for DIV/DIVU set lo = quotient and hi = remainder; for DIV, quotient sign = sign(A) xor sign(B) and remainder sign = sign(A).
REQ-021 SHALL for DIV 0x80000000 / 0xFFFFFFFF produce lo = 0x80000000, hi = 0; no trap.
REQ-022 SHALL for B == 0 on DIV/DIVU still take 33 cycles, then set hi = A (original value), lo = 0xFFFFFFFF, and pulse divByZero.
REQ-023 SHALL in IDLE without start write hi = writeData on hiWrite and lo = writeData on loWrite, next edge; both strobes together write both.
REQ-024 SHALL on start together with hiWrite/loWrite accept start and drop the writes.
REQ-025 SHALL ignore hiWrite/loWrite while busy.
REQ-026 SHALL accept a start presented in the cycle done is high; state is IDLE, so back-to-back operations are allowed.
REQ-027 SHALL hold hi/lo stable except on the FIX edge or an accepted mthi/mtlo.

Reset
REQ-028 SHALL on resetN low at a rising edge force state = IDLE, counter = 0, hi = 0, lo = 0, busy = 0, done = 0, divByZero = 0.
REQ-029 SHALL on reset mid-operation (RUN or FIX) discard the operation without writing hi/lo; reset overrides start and mthi/mtlo in the same cycle.

Structure
REQ-030 SHALL place the op encodings (MULT/MULTU/DIV/DIVU) and the FSM state encoding in the shared package, alongside the ALU control codes.
REQ-031 SHALL factor the per-iteration datapath into one sub-module, mul_div_step: combinational shift-add / shift-subtract of one iteration.

Verification
REQ-032 SHALL cover MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after acceptance; busy high for 33 cycles.
REQ-033 SHALL cover MULT A=0xFFFFFFFD (-3), B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15).
REQ-034 SHALL cover DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU A=100, B=7 back-to-back with start in the done cycle -> lo=14, hi=2.
REQ-035 SHALL cover DIVU A=5, B=0 -> hi=5, lo=0xFFFFFFFF, divByZero and done high for one cycle.
REQ-036 SHALL cover resetN low at RUN iteration 10 of MULTU 3*4 -> next cycle busy=0, hi=lo=0, no done; a new MULTU 3*4 then gives lo=12, hi=0.
REQ-037 SHALL cover hiWrite with writeData=0x1234 while busy -> hi unchanged; loWrite with writeData=0xABCD in IDLE -> lo=0xABCD next cycle; start while busy -> ignored, the first result is unaffected.
